// File: rtl/fifo_burst_reader_pkg.sv
// fifo_burst_reader_pkg: shared FSM encoding and defaults
// for the FIFO burst reader slice.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int BURST_CNT_W = 16;

endpackage

// File: rtl/fifo_burst_reader_if.sv
// fifo_burst_reader_if: valid/ready stream with a last tag.
// master drives out_data/out_valid/out_last, slave drives out_ready.
interface fifo_burst_reader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/fifo_burst_reader_skid_buf.sv
// fifo_burst_reader_skid_buf: 2-entry in-order buffer.
// Ports: push/din write the tail, pop drops head, occ = entries.
module fifo_burst_reader_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0_q;
  logic [W-1:0] ent1_q;
  logic [1:0]   occ_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      unique case (1'b1)
        push && !pop: begin
          if (occ_q == 2'd0) ent0_q <= din;
          else               ent1_q <= din;
          occ_q <= occ_q + 2'd1;
        end
        !push && pop: begin
          ent0_q <= ent1_q;
          occ_q  <= occ_q - 2'd1;
        end
        push && pop: begin
          if (occ_q == 2'd2) begin
            ent0_q <= ent1_q;
            ent1_q <= din;
          end else begin
            ent0_q <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0_q;
  assign occ  = occ_q;

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(push && !pop && occ_q == 2'd2)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    !(pop && occ_q == 2'd0)
  );

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a FIFO (re/empty/half/data) and re-presents
// the words on strm as BURST_LEN-word bursts; busy, burst_cnt status.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DATA_W        = DEF_DATA_W,
  parameter int BURST_LEN     = 4,
  parameter bit START_ON_HALF = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   fifo_empty,
  input  logic                   fifo_half,
  input  logic [DATA_W-1:0]      fifo_data,
  output logic                   fifo_re,
  fifo_burst_reader_if.master    strm,
  output logic                   busy,
  output logic [BURST_CNT_W-1:0] burst_cnt
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW:0]   BL_W   = (CW+1)'(BURST_LEN);
  localparam logic [CW-1:0] LAST_I = CW'(BURST_LEN - 1);

  state_t state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic          re_q, re_d;
  logic [BURST_CNT_W-1:0] bcnt_q;

  logic [1:0]        occ;
  logic [DATA_W:0]   head;
  logic              pop;
  logic              start;
  logic              room;
  logic [2:0]        lvl;
  logic              push_last;

  // The registered strobe is masked by empty so a request that
  // outlived the last FIFO word never reaches the FIFO; issued
  // counts completed reads only.
  assign fifo_re   = re_q & ~fifo_empty;
  assign pop       = strm.out_valid & strm.out_ready;
  assign start     = START_ON_HALF ? fifo_half : ~fifo_empty;
  assign lvl       = 3'(occ) + 3'(re_q) - 3'(pop);
  assign room      = lvl <= 3'd1;
  assign push_last = issued_q == LAST_I;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      issued_q <= '0;
      re_q     <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      re_q     <= re_d;
      if (state_q == FLUSH && pop && strm.out_last)
        bcnt_q <= bcnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    re_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (en && start) begin
          state_d  = RUN;
          issued_d = '0;
        end
      end
      RUN: begin
        re_d = ~fifo_empty && room &&
               ((CW+1)'(issued_q) + (CW+1)'(re_q) < BL_W);
        if (fifo_re) begin
          issued_d = issued_q + 1'b1;
          if (push_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (pop && strm.out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  fifo_burst_reader_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_re),
    .din  ({push_last, fifo_data}),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  assign strm.out_data  = head[DATA_W-1:0];
  assign strm.out_last  = head[DATA_W];
  assign strm.out_valid = occ != 2'd0;
  assign busy           = state_q != IDLE;
  assign burst_cnt      = bcnt_q;

  a_re_not_empty: assert property (
    @(posedge clk) disable iff (!rst)
    !(fifo_re && fifo_empty)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized self-checking bench with a
// queue-based stream model and behavioural FIFOs for two configs.
module tb_fifo_burst_reader;

  localparam int DW = 8;
  localparam int BL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en0, en1;
  logic re0, re1, busy0, busy1;
  logic [15:0] bc0, bc1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] wp0, rp0, wp1, rp1;
  logic [7:0] cnt0, cnt1;
  logic empty0, empty1, half0, half1;

  assign cnt0   = wp0 - rp0;
  assign cnt1   = wp1 - rp1;
  assign empty0 = cnt0 == 8'd0;
  assign empty1 = cnt1 == 8'd0;
  assign half0  = cnt0 >= 8'd4;
  assign half1  = cnt1 >= 8'd4;

  fifo_burst_reader_if #(.DATA_W(DW)) s0 ();
  fifo_burst_reader_if #(.DATA_W(DW)) s1 ();

  fifo_burst_reader #(
    .DATA_W(DW), .BURST_LEN(BL), .START_ON_HALF(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en0),
    .fifo_empty(empty0), .fifo_half(half0),
    .fifo_data(mem0[rp0]), .fifo_re(re0),
    .strm(s0), .busy(busy0), .burst_cnt(bc0)
  );

  fifo_burst_reader #(
    .DATA_W(DW), .BURST_LEN(BL), .START_ON_HALF(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en1),
    .fifo_empty(empty1), .fifo_half(half1),
    .fifo_data(mem1[rp1]), .fifo_re(re1),
    .strm(s1), .busy(busy1), .burst_cnt(bc1)
  );

  always @(posedge clk or negedge rst)
    if (!rst) rp0 <= 8'd0;
    else if (re0 && !empty0) rp0 <= rp0 + 8'd1;

  always @(posedge clk or negedge rst)
    if (!rst) rp1 <= 8'd0;
    else if (re1 && !empty1) rp1 <= rp1 + 8'd1;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q [$];
  int         acc_total;
  logic [7:0] obs_d [$];
  bit         obs_l [$];
  int         obs_c [$];
  int         cyc, rd_cnt, hold_err, re_err;
  bit         stall_q;
  logic [7:0] stall_d;
  logic       stall_l;

  task automatic push0(input logic [7:0] w);
    mem0[wp0] = w;
    wp0 = wp0 + 8'd1;
    exp_q.push_back(w);
  endtask

  task automatic push1(input logic [7:0] w);
    mem1[wp1] = w;
    wp1 = wp1 + 8'd1;
  endtask

  task automatic clear_obs();
    obs_d.delete();
    obs_l.delete();
    obs_c.delete();
  endtask

  // One clock of dut0 traffic; records accepted beats and protocol
  // observations, compares nothing itself.
  task automatic step(input bit rdy, input bit do_push,
                      input logic [7:0] w);
    @(negedge clk);
    if (do_push) push0(w);
    s0.out_ready = rdy;
    #1;
    cyc++;
    if (re0 && empty0) re_err++;
    if (re0) rd_cnt++;
    if (stall_q && (!s0.out_valid || s0.out_data !== stall_d ||
                    s0.out_last !== stall_l)) hold_err++;
    if (s0.out_valid && rdy) begin
      obs_d.push_back(s0.out_data);
      obs_l.push_back(s0.out_last);
      obs_c.push_back(cyc);
    end
    stall_q = s0.out_valid && !rdy;
    stall_d = s0.out_data;
    stall_l = s0.out_last;
  endtask

  task automatic wait_idle0();
    for (int k = 0; k < 40 && busy0; k++) step(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en0 = 1'b1;
    en1 = 1'b0;
    wp0 = 8'd0;
    wp1 = 8'd0;
    push0(8'hA1);
    push0(8'hA2);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (re0 !== 1'b0) begin
      errors++; $display("FAIL reset_re: got %b want 0", re0);
    end
    checks++;
    if (s0.out_valid !== 1'b0 || s0.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_last: got %b%b want 00",
               s0.out_valid, s0.out_last);
    end
    checks++;
    if (s0.out_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got %h want 00", s0.out_data);
    end
    checks++;
    if (busy0 !== 1'b0 || bc0 !== 16'd0) begin
      errors++;
      $display("FAIL reset_busy_cnt: got %b/%0d want 0/0", busy0, bc0);
    end
    en0 = 1'b0;
    wp0 = 8'd0;
    exp_q.delete();
    acc_total = 0;
    stall_q = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_streaming();
    clear_obs();
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push0(8'(8'h11 * i));
    en0 = 1'b1;
    for (int k = 0; k < 60 && obs_d.size() < 8; k++)
      step(1'b1, 1'b0, 8'h00);
    en0 = 1'b0;
    wait_idle0();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      bit l;
      w = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      l = (acc_total % BL) == BL - 1;
      acc_total++;
      checks++;
      if (i >= obs_d.size()) begin
        errors++; $display("FAIL stream_beat%0d: got none want %h", i, w);
      end else if (obs_d[i] !== w || obs_l[i] !== l) begin
        errors++;
        $display("FAIL stream_beat%0d: got %h/%b want %h/%b",
                 i, obs_d[i], obs_l[i], w, l);
      end
    end
    checks++;
    if (obs_c.size() != 8 || obs_c[3] - obs_c[0] != 3 ||
        obs_c[7] - obs_c[4] != 3) begin
      errors++;
      $display("FAIL stream_rate: got %0d beats, not back-to-back in bursts",
               obs_c.size());
    end
    checks++;
    if (bc0 !== 16'(acc_total / BL) || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL stream_bursts: got %0d/%b want %0d/0",
               bc0, busy0, acc_total / BL);
    end
  endtask

  task automatic test_backpressure();
    clear_obs();
    rd_cnt = 0;
    hold_err = 0;
    @(negedge clk);
    for (int i = 1; i <= 8; i++) push0(8'(8'h11 * i));
    en0 = 1'b1;
    repeat (8) step(1'b0, 1'b0, 8'h00);
    checks++;
    if (rd_cnt > 2) begin
      errors++; $display("FAIL bp_reads: got %0d want <=2", rd_cnt);
    end
    checks++;
    if (s0.out_valid !== 1'b1 || s0.out_data !== 8'h11) begin
      errors++;
      $display("FAIL bp_head: got %b/%h want 1/11",
               s0.out_valid, s0.out_data);
    end
    for (int k = 0; k < 80 && obs_d.size() < 8; k++)
      step(1'($urandom_range(0, 1)), 1'b0, 8'h00);
    en0 = 1'b0;
    wait_idle0();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      bit l;
      w = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      l = (acc_total % BL) == BL - 1;
      acc_total++;
      checks++;
      if (i >= obs_d.size()) begin
        errors++; $display("FAIL bp_beat%0d: got none want %h", i, w);
      end else if (obs_d[i] !== w || obs_l[i] !== l) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b",
                 i, obs_d[i], obs_l[i], w, l);
      end
    end
    checks++;
    if (hold_err != 0 || obs_d.size() != 8) begin
      errors++;
      $display("FAIL bp_stable: got %0d hold errs, %0d beats want 0, 8",
               hold_err, obs_d.size());
    end
    checks++;
    if (bc0 !== 16'(acc_total / BL)) begin
      errors++;
      $display("FAIL bp_bursts: got %0d want %0d", bc0, acc_total / BL);
    end
  endtask

  task automatic test_underflow();
    clear_obs();
    re_err = 0;
    @(negedge clk);
    push0(8'($urandom));
    push0(8'($urandom));
    en0 = 1'b1;
    repeat (12) step(1'b1, 1'b0, 8'h00);
    checks++;
    if (obs_d.size() != 2 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL uf_stall: got %0d beats busy %b want 2 busy 1",
               obs_d.size(), busy0);
    end
    en0 = 1'b0;
    step(1'b1, 1'b1, 8'($urandom));
    step(1'b1, 1'b1, 8'($urandom));
    for (int k = 0; k < 20 && obs_d.size() < 4; k++)
      step(1'b1, 1'b0, 8'h00);
    wait_idle0();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      bit l;
      w = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      l = (acc_total % BL) == BL - 1;
      acc_total++;
      checks++;
      if (i >= obs_d.size()) begin
        errors++; $display("FAIL uf_beat%0d: got none want %h", i, w);
      end else if (obs_d[i] !== w || obs_l[i] !== l) begin
        errors++;
        $display("FAIL uf_beat%0d: got %h/%b want %h/%b",
                 i, obs_d[i], obs_l[i], w, l);
      end
    end
    checks++;
    if (re_err != 0) begin
      errors++; $display("FAIL uf_re_empty: got %0d want 0", re_err);
    end
    checks++;
    if (bc0 !== 16'(acc_total / BL) || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL uf_bursts: got %0d/%b want %0d/0",
               bc0, busy0, acc_total / BL);
    end
  endtask

  task automatic test_start_on_half();
    logic [7:0] w1 [4];
    int got;
    for (int i = 0; i < 4; i++) w1[i] = 8'($urandom);
    s1.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) push1(w1[i]);
    en1 = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL half_wait: got busy %b want 0", busy1);
    end
    @(negedge clk);
    push1(w1[3]);
    @(posedge clk);
    #1;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL half_start: got busy %b want 1", busy1);
    end
    en1 = 1'b0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (s1.out_valid && got < 4) begin
        checks++;
        if (s1.out_data !== w1[got] || s1.out_last !== (got == 3)) begin
          errors++;
          $display("FAIL half_beat%0d: got %h/%b want %h/%b", got,
                   s1.out_data, s1.out_last, w1[got], got == 3);
        end
        got++;
      end
    end
    checks++;
    if (got != 4 || bc1 !== 16'd1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL half_done: got %0d beats cnt %0d busy %b want 4 1 0",
               got, bc1, busy1);
    end
  endtask

  task automatic test_midburst_reset();
    bit seen;
    clear_obs();
    @(negedge clk);
    for (int i = 0; i < 4; i++) push0(8'($urandom));
    en0 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1'b1, 1'b0, 8'h00);
      seen = re0;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL mr_inflight: got no read want read");
    end
    rst = 1'b0;
    wp0 = 8'd0;
    wp1 = 8'd0;
    #1;
    checks++;
    if (re0 !== 1'b0 || s0.out_valid !== 1'b0 || busy0 !== 1'b0 ||
        bc0 !== 16'd0 || s0.out_data !== 8'h00) begin
      errors++;
      $display("FAIL mr_reset: got re%b v%b b%b c%0d d%h want all 0",
               re0, s0.out_valid, busy0, bc0, s0.out_data);
    end
    exp_q.delete();
    acc_total = 0;
    stall_q = 1'b0;
    clear_obs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push0(8'($urandom));
    for (int k = 0; k < 30 && obs_d.size() < 4; k++)
      step(1'b1, 1'b0, 8'h00);
    en0 = 1'b0;
    wait_idle0();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] w;
      bit l;
      w = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      l = (acc_total % BL) == BL - 1;
      acc_total++;
      checks++;
      if (i >= obs_d.size()) begin
        errors++; $display("FAIL mr_beat%0d: got none want %h", i, w);
      end else if (obs_d[i] !== w || obs_l[i] !== l) begin
        errors++;
        $display("FAIL mr_beat%0d: got %h/%b want %h/%b",
                 i, obs_d[i], obs_l[i], w, l);
      end
    end
    checks++;
    if (bc0 !== 16'(acc_total / BL)) begin
      errors++;
      $display("FAIL mr_bursts: got %0d want %0d", bc0, acc_total / BL);
    end
  endtask

  task automatic test_random();
    int pushed;
    clear_obs();
    hold_err = 0;
    re_err = 0;
    pushed = 0;
    en0 = 1'b1;
    for (int k = 0; k < 400 && obs_d.size() < 12; k++) begin
      bit p;
      p = pushed < 12 && $urandom_range(0, 2) != 0;
      if (p) pushed++;
      step(1'($urandom_range(0, 1)), p, 8'($urandom));
    end
    en0 = 1'b0;
    wait_idle0();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] w;
      bit l;
      w = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      l = (acc_total % BL) == BL - 1;
      acc_total++;
      checks++;
      if (i >= obs_d.size()) begin
        errors++; $display("FAIL rnd_beat%0d: got none want %h", i, w);
      end else if (obs_d[i] !== w || obs_l[i] !== l) begin
        errors++;
        $display("FAIL rnd_beat%0d: got %h/%b want %h/%b",
                 i, obs_d[i], obs_l[i], w, l);
      end
    end
    checks++;
    if (hold_err != 0 || re_err != 0) begin
      errors++;
      $display("FAIL rnd_protocol: got hold %0d re %0d want 0 0",
               hold_err, re_err);
    end
    checks++;
    if (bc0 !== 16'(acc_total / BL) || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL rnd_bursts: got %0d/%b want %0d/0",
               bc0, busy0, acc_total / BL);
    end
  endtask

  initial begin
    s0.out_ready = 1'b0;
    s1.out_ready = 1'b1;
    cyc = 0;
    rd_cnt = 0;
    hold_err = 0;
    re_err = 0;
    stall_q = 1'b0;
    stall_d = 8'h00;
    stall_l = 1'b0;
    acc_total = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_underflow();
    test_start_on_half();
    test_midburst_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
